// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch controller.
// Used by stopwatch_ctrl (optional lap feature: STOPWATCH_LAP_EN) and bcd_digit.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StLap   = 2'b11
    } sw_state_e;

    localparam logic [3:0] BcdMax9 = 4'd9;
    localparam logic [3:0] BcdMax5 = 4'd5;

    localparam int unsigned DefaultTickDiv = 500000;

    function automatic logic is_counting(sw_state_e s);
        return (s == StRun) || (s == StLap);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button pulses in, display and status out, for the stopwatch controller.
interface stopwatch_ctrl_if;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic [15:0] digits;
    logic        running;
    logic        overflow;

    modport master (
        output start_stop, clear, lap,
        input  digits, running, overflow
    );

    modport slave (
        input  start_stop, clear, lap,
        output digits, running, overflow
    );
endinterface

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD counter digit with terminal value MAX; carry flags a wrap on this increment.
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (inc) begin
            q_d = (q_q == MAX) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc & (q_q == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch: run/pause FSM, 0.01 s prescaler, SS.hh BCD count with optional lap freeze.
// Lap support is compiled in only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = DefaultTickDiv
) (
    input  logic             clock,
    input  logic             reset_n,
    stopwatch_ctrl_if.slave  sw
);

    localparam logic [23:0] TickLast = 24'(TICK_DIV - 1);

    sw_state_e   state_d, state_q;
    logic [23:0] presc_d, presc_q;
    logic        overflow_d, overflow_q;
    logic        counting, tick, lap_pulse;
    logic [3:0]  q_hund, q_tenth, q_sec_ones, q_sec_tens;
    logic        c_hund, c_tenth, c_sec_ones, c_sec_tens;
    logic [15:0] live;

    assign counting = is_counting(state_q);
    assign tick     = counting && (presc_q == TickLast);
    assign live     = {q_sec_tens, q_sec_ones, q_tenth, q_hund};

`ifdef STOPWATCH_LAP_EN
    assign lap_pulse = sw.lap;
`else
    logic unused_lap;
    assign unused_lap = sw.lap;
    assign lap_pulse  = 1'b0;
`endif

    // clear beats start_stop beats lap; losers are dropped
    always_comb begin
        state_d = state_q;
        if (sw.clear) begin
            state_d = StIdle;
        end else if (sw.start_stop) begin
            unique case (state_q)
                StIdle:  state_d = StRun;
                StRun:   state_d = StPause;
                StPause: state_d = StRun;
                StLap:   state_d = StPause;
                default: state_d = StIdle;
            endcase
        end else if (lap_pulse) begin
            if (state_q == StRun) begin
                state_d = StLap;
            end else if (state_q == StLap) begin
                state_d = StRun;
            end
        end
    end

    // PAUSE keeps the partial tick so a resume loses no time
    always_comb begin
        presc_d = presc_q;
        if (sw.clear || (state_q == StIdle)) begin
            presc_d = 24'd0;
        end else if (counting) begin
            presc_d = tick ? 24'd0 : presc_q + 24'd1;
        end
    end

    assign overflow_d = c_sec_tens & ~sw.clear;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            presc_q    <= 24'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            overflow_q <= overflow_d;
        end
    end

    bcd_digit #(.MAX(BcdMax9)) u_hund (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (sw.clear),
        .inc     (tick),
        .q       (q_hund),
        .carry   (c_hund)
    );

    bcd_digit #(.MAX(BcdMax9)) u_tenth (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (sw.clear),
        .inc     (c_hund),
        .q       (q_tenth),
        .carry   (c_tenth)
    );

    bcd_digit #(.MAX(BcdMax9)) u_sec_ones (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (sw.clear),
        .inc     (c_tenth),
        .q       (q_sec_ones),
        .carry   (c_sec_ones)
    );

    bcd_digit #(.MAX(BcdMax5)) u_sec_tens (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (sw.clear),
        .inc     (c_sec_ones),
        .q       (q_sec_tens),
        .carry   (c_sec_tens)
    );

`ifdef STOPWATCH_LAP_EN
    logic [15:0] lap_d, lap_q;

    // snapshot the pre-edge count; the live counters keep running underneath
    always_comb begin
        lap_d = lap_q;
        if (sw.clear) begin
            lap_d = 16'h0000;
        end else if ((state_q == StRun) && (state_d == StLap)) begin
            lap_d = live;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lap_q <= 16'h0000;
        end else begin
            lap_q <= lap_d;
        end
    end

    assign sw.digits = (state_q == StLap) ? lap_q : live;
`else
    assign sw.digits = live;
`endif

    assign sw.running  = counting;
    assign sw.overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=4 and a centisecond-count reference model.
module tb_stopwatch_ctrl;

    localparam int TickDiv = 4;
`ifdef STOPWATCH_LAP_EN
    localparam bit LapEn = 1'b1;
`else
    localparam bit LapEn = 1'b0;
`endif

    localparam int MIdle  = 0;
    localparam int MRun   = 1;
    localparam int MPause = 2;
    localparam int MLap   = 3;

    logic clock;
    logic reset_n;

    stopwatch_ctrl_if sw ();

    stopwatch_ctrl #(.TICK_DIV(TickDiv)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .sw      (sw)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: elapsed time as plain centiseconds
    int m_cs, m_pre, m_lap, m_mode;
    bit m_ovf;

    function automatic logic [15:0] to_bcd(input int cs);
        int v;
        v = ((cs / 1000) << 12) | (((cs / 100) % 10) << 8) | (((cs / 10) % 10) << 4) | (cs % 10);
        return 16'(v);
    endfunction

    function automatic logic [15:0] exp_digits();
        return (m_mode == MLap) ? to_bcd(m_lap) : to_bcd(m_cs);
    endfunction

    function automatic logic exp_running();
        return (m_mode == MRun) || (m_mode == MLap);
    endfunction

    task automatic model_reset();
        m_cs = 0; m_pre = 0; m_lap = 0; m_mode = MIdle; m_ovf = 0;
    endtask

    task automatic model_edge(input bit st, input bit cl, input bit lp);
        int old_cs;
        bit active;
        active = (m_mode == MRun) || (m_mode == MLap);
        old_cs = m_cs;
        m_ovf  = 0;
        if (cl) begin
            m_cs = 0; m_pre = 0; m_lap = 0; m_mode = MIdle;
        end else begin
            if (active) begin
                if (m_pre == TickDiv - 1) begin
                    m_pre = 0;
                    m_cs  = (m_cs + 1) % 6000;
                    m_ovf = (m_cs == 0);
                end else begin
                    m_pre++;
                end
            end
            if (st) begin
                case (m_mode)
                    MIdle:   m_mode = MRun;
                    MRun:    m_mode = MPause;
                    MPause:  m_mode = MRun;
                    default: m_mode = MPause;
                endcase
            end else if (lp && LapEn) begin
                if (m_mode == MRun) begin
                    m_lap  = old_cs;
                    m_mode = MLap;
                end else if (m_mode == MLap) begin
                    m_mode = MRun;
                end
            end
        end
    endtask

    // apply pulses for one edge; outputs are then sampled 1 time unit after it
    task automatic step(input bit st, input bit cl, input bit lp);
        sw.start_stop = st;
        sw.clear      = cl;
        sw.lap        = lp;
        @(posedge clock);
        model_edge(st, cl, lp);
        #1;
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        sw.lap        = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (sw.digits !== 16'h0000) begin
            n_fail++; $display("FAIL reset_digits: got %h want 0000", sw.digits);
        end
        n_checks++;
        if (sw.running !== 1'b0) begin
            n_fail++; $display("FAIL reset_running: got %b want 0", sw.running);
        end
        n_checks++;
        if (sw.overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow: got %b want 0", sw.overflow);
        end
    endtask

    task automatic test_basic_count();
        step(1, 0, 0);
        repeat (40) step(0, 0, 0);
        n_checks++;
        if (sw.digits !== 16'h0010) begin
            n_fail++; $display("FAIL basic_digits: got %h want 0010", sw.digits);
        end
        n_checks++;
        if (sw.running !== 1'b1) begin
            n_fail++; $display("FAIL basic_running: got %b want 1", sw.running);
        end
    endtask

    task automatic test_overflow();
        step(0, 1, 0);
        step(1, 0, 0);
        repeat (5999 * TickDiv) step(0, 0, 0);
        n_checks++;
        if (sw.digits !== 16'h5999) begin
            n_fail++; $display("FAIL ovf_at_max: got %h want 5999", sw.digits);
        end
        repeat (TickDiv - 1) begin
            step(0, 0, 0);
            n_checks++;
            if (sw.overflow !== 1'b0 || sw.digits !== 16'h5999) begin
                n_fail++;
                $display("FAIL ovf_early: got ovf=%b dig=%h want ovf=0 dig=5999",
                         sw.overflow, sw.digits);
            end
        end
        step(0, 0, 0);
        n_checks++;
        if (sw.digits !== 16'h0000 || sw.overflow !== 1'b1 || sw.running !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_wrap: got dig=%h ovf=%b run=%b want 0000 1 1",
                     sw.digits, sw.overflow, sw.running);
        end
        step(0, 0, 0);
        n_checks++;
        if (sw.overflow !== 1'b0 || sw.running !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_pulse_len: got ovf=%b run=%b want 0 1", sw.overflow, sw.running);
        end
    endtask

    task automatic test_pause_resume();
        step(0, 1, 0);
        step(1, 0, 0);
        repeat (9) step(0, 0, 0);
        step(1, 0, 0);
        repeat (20) begin
            step(0, 0, 0);
            n_checks++;
            if (sw.digits !== 16'h0002 || sw.running !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_hold: got dig=%h run=%b want 0002 0", sw.digits, sw.running);
            end
        end
        step(1, 0, 0);
        step(0, 0, 0);
        n_checks++;
        if (sw.digits !== 16'h0002) begin
            n_fail++; $display("FAIL resume_early: got %h want 0002", sw.digits);
        end
        step(0, 0, 0);
        n_checks++;
        if (sw.digits !== 16'h0003) begin
            n_fail++; $display("FAIL resume_tick: got %h want 0003", sw.digits);
        end
    endtask

    task automatic test_lap();
        logic [15:0] want_frozen;
        step(0, 1, 0);
        step(1, 0, 0);
        repeat (5 * TickDiv) step(0, 0, 0);
        step(0, 0, 1);
        repeat (12) step(0, 0, 0);
        want_frozen = LapEn ? 16'h0005 : 16'h0008;
        n_checks++;
        if (sw.digits !== want_frozen) begin
            n_fail++; $display("FAIL lap_frozen: got %h want %h", sw.digits, want_frozen);
        end
        n_checks++;
        if (sw.running !== 1'b1) begin
            n_fail++; $display("FAIL lap_running: got %b want 1", sw.running);
        end
        step(0, 0, 1);
        n_checks++;
        if (sw.digits !== 16'h0008) begin
            n_fail++; $display("FAIL lap_release: got %h want 0008", sw.digits);
        end
    endtask

    task automatic test_clear_priority();
        step(0, 1, 0);
        step(1, 0, 0);
        repeat (6) step(0, 0, 0);
        step(1, 1, 0);
        n_checks++;
        if (sw.digits !== 16'h0000 || sw.running !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_prio: got dig=%h run=%b want 0000 0", sw.digits, sw.running);
        end
        repeat (6) step(0, 0, 0);
        n_checks++;
        if (sw.digits !== 16'h0000 || sw.running !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_idle: got dig=%h run=%b want 0000 0", sw.digits, sw.running);
        end
    endtask

    task automatic test_async_reset();
        step(1, 0, 0);
        repeat (5 * TickDiv) step(0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (sw.digits !== 16'h0000 || sw.running !== 1'b0 || sw.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got dig=%h run=%b ovf=%b want 0000 0 0",
                     sw.digits, sw.running, sw.overflow);
        end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (TickDiv + 1) step(0, 0, 0);
        n_checks++;
        if (sw.digits !== 16'h0000 || sw.running !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got dig=%h run=%b want 0000 0", sw.digits, sw.running);
        end
    endtask

    task automatic test_random();
        bit st, cl, lp;
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 24) == 0);
            cl = ($urandom_range(0, 199) == 0);
            lp = ($urandom_range(0, 14) == 0);
            step(st, cl, lp);
            n_checks++;
            if (sw.digits !== exp_digits() || sw.running !== exp_running() ||
                sw.overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL random cyc %0d: got dig=%h run=%b ovf=%b want %h %b %b",
                         i, sw.digits, sw.running, sw.overflow,
                         exp_digits(), exp_running(), m_ovf);
            end
        end
    endtask

    initial begin
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        sw.lap        = 1'b0;
        reset_n       = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        test_reset();
        reset_n = 1'b1;
        @(negedge clock);
        test_basic_count();
        test_overflow();
        test_pause_resume();
        test_lap();
        test_clear_priority();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
